// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and
// writes them sequentially from word 0 into the instruction memory, holding
// the CPU off for the duration of the load.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_W    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  logic [1:0]        state;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W:0]   word_cnt;
  logic [23:0]       asm_buf;
  logic              accept;
  logic              count_ok;
  logic [ADDR_W:0]   ww_next;

  assign accept   = byte_valid && byte_ready;
  assign count_ok = (num_words != '0) && (num_words <= DEPTH_W);
  assign ww_next  = words_written + ONE_W;

  // Handshake and status outputs decode directly from the current state.
  always_comb begin
    byte_ready = (state == S_LOAD);
    mem_we     = (state == S_WRITE);
    busy       = (state == S_LOAD) || (state == S_WRITE);
    cpu_hold   = (state != S_IDLE);
    done       = (state == S_DONE);
  end

  // Load sequencer: byte assembly, write staging, word counting, error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      byte_idx      <= '0;
      word_idx      <= '0;
      word_cnt      <= '0;
      asm_buf       <= '0;
      mem_waddr     <= '0;
      mem_wdata     <= '0;
      words_written <= '0;
      error         <= 1'b0;
    end else begin
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (count_ok) begin
              word_cnt      <= num_words;
              word_idx      <= '0;
              words_written <= '0;
              byte_idx      <= '0;
              state         <= S_LOAD;
            end else begin
              error <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (abort) begin
            byte_idx <= '0;
            state    <= S_IDLE;
          end else if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_buf[7:0]   <= byte_data;
              2'd1: asm_buf[15:8]  <= byte_data;
              2'd2: asm_buf[23:16] <= byte_data;
              default: begin
                // The final byte is merged straight into the write register so
                // mem_we can fire on the very next cycle.
                mem_wdata <= {byte_data, asm_buf};
                mem_waddr <= word_idx;
                state     <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            word_idx      <= word_idx + ONE_A;
            words_written <= ww_next;
            state         <= (ww_next == word_cnt) ? S_DONE : S_LOAD;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  num_words = '0;
  logic        abort = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [6:0]  words_written;

  int checks = 0;
  int fails  = 0;

  imem_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .abort(abort), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Event log sampled mid-cycle.
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          overlap_cnt = 0;
  logic [5:0]  wr_addr [128];
  logic [31:0] wr_data [128];

  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_cnt < 128) begin
        wr_addr[wr_cnt] = mem_waddr;
        wr_data[wr_cnt] = mem_wdata;
      end
      wr_cnt++;
    end
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (mem_we && byte_ready) overlap_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [6:0] n);
    num_words = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int g;
    g = 0;
    if (gap) begin
      byte_valid = 1'b0;
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && g < 20) begin
      tick();
      g++;
    end
    if (!byte_ready) begin
      checks++;
      fails++;
      $display("FAIL send_byte_timeout: byte_ready=%b required 1", byte_ready);
    end else begin
      tick();
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int g;
    g = 0;
    while (!done && g < bound) begin
      tick();
      g++;
    end
    checks++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL wait_done: done=%b required 1 within %0d cycles", done, bound);
    end
  endtask

  function automatic logic [31:0] full_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b ^ 8'h5A, b, 8'hC3, ~b};
  endfunction

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({byte_ready, mem_we, cpu_hold, busy, done, error} !== 6'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b required 000000",
               {byte_ready, mem_we, cpu_hold, busy, done, error});
    end
    checks++;
    if (mem_waddr !== 6'd0 || mem_wdata !== 32'd0 || words_written !== 7'd0) begin
      fails++;
      $display("FAIL reset_regs: addr=%0d data=%h ww=%0d required 0 0 0",
               mem_waddr, mem_wdata, words_written);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int wbase, dbase;
    wbase = wr_cnt;
    dbase = done_cnt;
    checks++;
    if (cpu_hold !== 1'b0) begin
      fails++;
      $display("FAIL single_hold_before: cpu_hold=%b required 0", cpu_hold);
    end
    pulse_start(7'd1);
    checks++;
    if (cpu_hold !== 1'b1 || busy !== 1'b1 || byte_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_load_flags: hold=%b busy=%b ready=%b required 1 1 1",
               cpu_hold, busy, byte_ready);
    end
    send_word(32'h00500093, 1'b0);
    checks++;
    if (mem_we !== 1'b1 || mem_waddr !== 6'd0 || mem_wdata !== 32'h00500093) begin
      fails++;
      $display("FAIL single_write: we=%b addr=%0d data=%h required 1 0 00500093",
               mem_we, mem_waddr, mem_wdata);
    end
    tick();
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b1 || busy !== 1'b0 || words_written !== 7'd1) begin
      fails++;
      $display("FAIL single_done: done=%b hold=%b busy=%b ww=%0d required 1 1 0 1",
               done, cpu_hold, busy, words_written);
    end
    tick();
    checks++;
    if (cpu_hold !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL single_release: hold=%b done=%b required 0 0", cpu_hold, done);
    end
    checks++;
    if (wr_cnt - wbase !== 1 || done_cnt - dbase !== 1) begin
      fails++;
      $display("FAIL single_counts: writes=%0d dones=%0d required 1 1",
               wr_cnt - wbase, done_cnt - dbase);
    end
  endtask

  task automatic test_toggle();
    logic [31:0] w [3];
    int wbase, dbase;
    w[0] = 32'h00500093;
    w[1] = 32'h00500113;
    w[2] = 32'h00208663;
    wbase = wr_cnt;
    dbase = done_cnt;
    pulse_start(7'd3);
    for (int i = 0; i < 3; i++) send_word(w[i], 1'b1);
    wait_done(10);
    checks++;
    if (wr_cnt - wbase !== 3) begin
      fails++;
      $display("FAIL toggle_write_count_at_done: got %0d required 3", wr_cnt - wbase);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr[wbase+i] !== 6'(i) || wr_data[wbase+i] !== w[i]) begin
        fails++;
        $display("FAIL toggle_write%0d: addr=%0d data=%h required %0d %h",
                 i, wr_addr[wbase+i], wr_data[wbase+i], i, w[i]);
      end
    end
    checks++;
    if (done_cnt - dbase !== 1 || words_written !== 7'd3 || overlap_cnt !== 0) begin
      fails++;
      $display("FAIL toggle_status: dones=%0d ww=%0d overlap=%0d required 1 3 0",
               done_cnt - dbase, words_written, overlap_cnt);
    end
  endtask

  task automatic test_bad_count();
    int wbase, ebase;
    wbase = wr_cnt;
    ebase = err_cnt;
    pulse_start(7'd0);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
      fails++;
      $display("FAIL bad_zero: error=%b busy=%b hold=%b required 1 0 0", error, busy, cpu_hold);
    end
    tick();
    checks++;
    if (error !== 1'b0) begin
      fails++;
      $display("FAIL bad_zero_pulse: error=%b required 0", error);
    end
    pulse_start(7'd65);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
      fails++;
      $display("FAIL bad_65: error=%b busy=%b hold=%b required 1 0 0", error, busy, cpu_hold);
    end
    tick();
    tick();
    checks++;
    if (err_cnt - ebase !== 2 || wr_cnt - wbase !== 0 || words_written !== 7'd3) begin
      fails++;
      $display("FAIL bad_summary: errors=%0d writes=%0d ww=%0d required 2 0 3",
               err_cnt - ebase, wr_cnt - wbase, words_written);
    end
  endtask

  task automatic test_abort();
    int wbase, dbase;
    wbase = wr_cnt;
    dbase = done_cnt;
    pulse_start(7'd2);
    send_word(32'h11223344, 1'b0);
    tick();
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    byte_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0 || byte_ready !== 1'b0 || words_written !== 7'd1) begin
      fails++;
      $display("FAIL abort_idle: busy=%b hold=%b ready=%b ww=%0d required 0 0 0 1",
               busy, cpu_hold, byte_ready, words_written);
    end
    repeat (4) tick();
    checks++;
    if (done_cnt - dbase !== 0 || wr_cnt - wbase !== 1 || wr_addr[wbase] !== 6'd0) begin
      fails++;
      $display("FAIL abort_log: dones=%0d writes=%0d addr0=%0d required 0 1 0",
               done_cnt - dbase, wr_cnt - wbase, wr_addr[wbase]);
    end
  endtask

  task automatic test_async_reset();
    int wbase;
    pulse_start(7'd4);
    send_word(32'hCAFEF00D, 1'b0);
    tick();
    send_byte(8'h01, 1'b0);
    byte_valid = 1'b1;
    byte_data  = 8'h02;
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({byte_ready, mem_we, cpu_hold, busy, done, error} !== 6'b0) begin
      fails++;
      $display("FAIL async_flags: got %b required 000000",
               {byte_ready, mem_we, cpu_hold, busy, done, error});
    end
    checks++;
    if (mem_waddr !== 6'd0 || mem_wdata !== 32'd0 || words_written !== 7'd0) begin
      fails++;
      $display("FAIL async_regs: addr=%0d data=%h ww=%0d required 0 0 0",
               mem_waddr, mem_wdata, words_written);
    end
    #2;
    rst = 1'b1;
    byte_valid = 1'b0;
    tick();
    wbase = wr_cnt;
    pulse_start(7'd1);
    send_word(32'hDEADBEEF, 1'b0);
    checks++;
    if (mem_we !== 1'b1 || mem_waddr !== 6'd0 || mem_wdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL async_reload_write: we=%b addr=%0d data=%h required 1 0 deadbeef",
               mem_we, mem_waddr, mem_wdata);
    end
    wait_done(5);
    tick();
    checks++;
    if (words_written !== 7'd1 || wr_cnt - wbase !== 1) begin
      fails++;
      $display("FAIL async_reload_count: ww=%0d writes=%0d required 1 1",
               words_written, wr_cnt - wbase);
    end
  endtask

  task automatic test_full();
    int wbase, dbase;
    wbase = wr_cnt;
    dbase = done_cnt;
    pulse_start(7'd64);
    for (int i = 0; i < 64; i++) begin
      if (i == 10 || i == 40) begin
        num_words = 7'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      send_word(full_word(i), 1'b0);
    end
    checks++;
    if (mem_we !== 1'b1 || mem_waddr !== 6'd63) begin
      fails++;
      $display("FAIL full_last_write: we=%b addr=%0d required 1 63", mem_we, mem_waddr);
    end
    wait_done(5);
    repeat (4) tick();
    checks++;
    if (wr_cnt - wbase !== 64 || done_cnt - dbase !== 1 || words_written !== 7'd64) begin
      fails++;
      $display("FAIL full_summary: writes=%0d dones=%0d ww=%0d required 64 1 64",
               wr_cnt - wbase, done_cnt - dbase, words_written);
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (wr_addr[wbase+i] !== 6'(i) || wr_data[wbase+i] !== full_word(i)) begin
        fails++;
        $display("FAIL full_write%0d: addr=%0d data=%h required %0d %h",
                 i, wr_addr[wbase+i], wr_data[wbase+i], i, full_word(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_toggle();
    test_bad_count();
    test_abort();
    test_async_reset();
    test_full();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the single-cycle core's instruction memory.
- Accepts a little-endian byte stream over a valid/ready handshake and assembles it into 32-bit instructions.
- Writes each instruction sequentially, from word 0, into the instruction memory write port.
- Holds the CPU off while a program is being loaded, so firmware images can be loaded at runtime instead of being hard-coded.

Parameters:
- DEPTH, 64: instruction memory depth in words.
- ADDR_W, 6: word-address width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load (sampled in IDLE only).
- num_words  input  ADDR_W+1  number of words to load, latched on start.
- abort  input  1  cancels an in-progress load.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  incoming program byte.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction memory write enable.
- mem_waddr  output  ADDR_W  word address for the write.
- mem_wdata  output  32  instruction word to write.
- cpu_hold  output  1  keeps the core's PC and fetch stalled while high.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse when the load completes.
- error  output  1  one-cycle pulse on a rejected start.
- words_written  output  ADDR_W+1  count of words committed in the current or last load.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE.
  - All outputs 0: byte_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, busy, done, error, words_written.
  - Internal byte index, word index and latched count are cleared.
  - Any partial word is discarded; memory words already written are not touched.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - byte_ready=0, busy=0, cpu_hold=0.
  - start with 1 <= num_words <= DEPTH: latch the count, clear the word index and words_written, go to LOAD.
  - start with num_words=0 or num_words>DEPTH: error=1 for exactly one cycle, remain in IDLE, words_written unchanged.
- LOAD:
  - byte_ready=1, busy=1, cpu_hold=1.
  - A byte is accepted only when byte_valid && byte_ready.
  - Byte k (k=0..3) of a word goes to bits [8k+7:8k] (little-endian).
  - Accepting byte 3 moves to WRITE on the next edge.
  - byte_valid low stalls indefinitely; there is no timeout.
- WRITE (exactly one cycle):
  - byte_ready=0.
  - mem_we=1, mem_waddr = word index, mem_wdata = assembled word.
  - On exit: word index and words_written increment.
  - If the new words_written equals the latched count, go to DONE; otherwise return to LOAD with byte index 0.
- DONE (one cycle):
  - done=1, busy=0, cpu_hold=1; next state IDLE.
  - cpu_hold drops on the cycle after done.
- Latency: the mem_we cycle immediately follows the edge that accepted byte 3. Minimum 5 cycles per word at full throughput.
- mem_waddr and mem_wdata are registered and hold their last values when mem_we=0.
- start is ignored outside IDLE.
- abort in LOAD or WRITE:
  - Takes priority over all other transitions.
  - Next state IDLE; no done pulse.
  - A WRITE in the same cycle as abort still completes its mem_we, but words_written does not increment.
  - The partial word is discarded; words_written reports words fully committed before the abort.
- abort in IDLE or DONE has no effect.
- Word index never exceeds DEPTH-1: the count check guarantees no wrap-around.
- byte_valid while byte_ready=0: the byte is not consumed; the sender must hold it.

Test Plan:
- Reset, then start with num_words=1 and bytes 93,00,50,00 at full rate -> mem_we pulses once with addr 0, data 0x00500093; done pulses once; words_written=1; cpu_hold high from the cycle after start until the cycle after done.
- num_words=3 with byte_valid toggling every other cycle, words 0x00500093, 0x00500113, 0x00208663 -> writes to addrs 0, 1, 2 in order with exactly those values; byte_ready never high in WRITE; done after the third write.
- start with num_words=0, then with num_words=65 -> each produces a one-cycle error pulse; state stays IDLE; no mem_we; cpu_hold stays 0.
- Load num_words=2; after word 0 is written and 2 bytes of word 1 accepted, assert abort -> IDLE next cycle; no done; words_written=1; no write to addr 1.
- Drive rst low asynchronously mid-byte during a 4-word load -> all outputs 0 immediately; after release, a fresh 1-word load writes to addr 0 correctly.
- num_words=64 full load -> final write at addr 63; done asserted; no write beyond addr 63; start pulses during the load are ignored.
